// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core (C) has priority, and a starvation guard lets
// the DMA/debug port (D) win. The winning command is registered onto the DMEM bus.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [BE_W-1:0]   c_be,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              c_gnt,
  output logic              d_gnt,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              core_stall,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       d_starved;
  logic       c_hs;
  logic       d_hs;
  logic       c_rd_pend;
  logic       d_rd_pend;

  // D only overrides C once it has lost STARVE_LIMIT consecutive cycles.
  always_comb begin
    d_starved  = (starve_cnt == LIMIT);
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    if (!rst) begin
      c_gnt = c_req & ~(d_req & d_starved);
      d_gnt = d_req & (~c_req | d_starved);
    end
    c_hs       = c_req & c_gnt;
    d_hs       = d_req & d_gnt;
    core_stall = c_req & ~c_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (d_req && !d_gnt) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Address/data/byte enables hold when idle; only en and we drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_en    <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      dmem_en <= c_hs | d_hs;
      dmem_we <= 1'b0;
      if (c_hs) begin
        dmem_we    <= c_we;
        dmem_addr  <= c_addr;
        dmem_wdata <= c_wdata;
        dmem_be    <= c_be;
      end else if (d_hs) begin
        dmem_we    <= d_we;
        dmem_addr  <= d_addr;
        dmem_wdata <= d_wdata;
        dmem_be    <= d_be;
      end
    end
  end

  // Read owner travels alongside dmem_en, then becomes rvalid when the data returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rd_pend <= 1'b0;
      d_rd_pend <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      c_rd_pend <= c_hs & ~c_we;
      d_rd_pend <= d_hs & ~d_we;
      c_rvalid  <= c_rd_pend;
      d_rvalid  <= d_rd_pend;
    end
  end

  assign c_rdata = dmem_rdata;
  assign d_rdata = dmem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cycle-level reference model is checked every cycle,
// alongside directed scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  c_be = '0, d_be = '0;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, core_stall;
  logic        dmem_en, dmem_we;
  logic [31:0] c_rdata, d_rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .c_rdata(c_rdata), .d_rdata(d_rdata), .core_stall(core_stall),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous memory: read data one cycle after a read command.
  always @(posedge clk) begin
    if (dmem_en && !dmem_we) dmem_rdata <= memData(dmem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca,
                               input logic [31:0] cd, input logic [3:0] cb,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [3:0] db);
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_be = cb;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_be = db;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: state after each edge, expressed as who won and what was issued.
  int          m_starve = 0;
  logic        m_en = 0, m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_be = 0;
  bit          m_crv [4];
  bit          m_drv [4];
  logic [31:0] m_dat [4];
  int          cyc = 0;

  always @(negedge clk) begin
    int winner;
    int s;
    winner = 0;
    if (!rst) begin
      if (c_req && (!d_req || m_starve < LIM)) winner = 1;
      else if (d_req) winner = 2;
    end
    s = cyc % 4;
    if (chk_en) begin
      checkOutput("c_gnt", 32'(c_gnt), 32'(winner == 1));
      checkOutput("d_gnt", 32'(d_gnt), 32'(winner == 2));
      checkOutput("core_stall", 32'(core_stall), 32'(c_req && winner != 1));
      checkOutput("dmem_en", 32'(dmem_en), 32'(m_en));
      checkOutput("dmem_we", 32'(dmem_we), 32'(m_we));
      checkOutput("dmem_addr", dmem_addr, m_addr);
      checkOutput("dmem_wdata", dmem_wdata, m_wdata);
      checkOutput("dmem_be", 32'(dmem_be), 32'(m_be));
      checkOutput("c_rvalid", 32'(c_rvalid), 32'(m_crv[s]));
      checkOutput("d_rvalid", 32'(d_rvalid), 32'(m_drv[s]));
      if (m_crv[s]) checkOutput("c_rdata", c_rdata, m_dat[s]);
      if (m_drv[s]) checkOutput("d_rdata", d_rdata, m_dat[s]);
    end
    m_crv[s] = 0;
    m_drv[s] = 0;
    if (rst) begin
      m_starve = 0; m_en = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      for (int i = 0; i < 4; i++) begin m_crv[i] = 0; m_drv[i] = 0; end
    end else begin
      if (d_req && winner != 2) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
      else m_starve = 0;
      m_en = (winner != 0);
      m_we = 0;
      if (winner == 1) begin
        m_we = c_we; m_addr = c_addr; m_wdata = c_wdata; m_be = c_be;
      end else if (winner == 2) begin
        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
      end
      if (winner != 0 && !m_we) begin
        m_crv[(cyc + 2) % 4] = (winner == 1);
        m_drv[(cyc + 2) % 4] = (winner == 2);
        m_dat[(cyc + 2) % 4] = memData(m_addr);
      end
    end
    cyc++;
  end

  initial begin
    // Reset held with both ports requesting.
    c_req = 1; d_req = 1; c_addr = 32'h10; d_addr = 32'h20;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    checkOutput("rst_c_gnt", 32'(c_gnt), 0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 0);
    checkOutput("rst_stall", 32'(core_stall), 1);
    checkOutput("rst_en", 32'(dmem_en), 0);
    checkOutput("rst_rvalid", 32'({c_rvalid, d_rvalid}), 0);

    // Continuous contention: C,C,C,C,D repeating from the first cycle out of reset.
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("pat_d_gnt", 32'(d_gnt), 32'(i % 5 == 4));
      checkOutput("pat_stall", 32'(core_stall), 32'(i % 5 == 4));
      if (i < 9) begin
        @(posedge clk); #1;
        c_addr = 32'h1000 + 32'(i * 4);
        d_addr = 32'h2000 + 32'(i * 4);
      end
    end
    idle(); idle(); idle();

    // C read of 0x100 returns 0xDEADBEEF two cycles after the handshake.
    applyStimulus(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("t2_gnt", 32'(c_gnt), 1);
    idle();
    @(negedge clk);
    checkOutput("t2_en", 32'(dmem_en), 1);
    checkOutput("t2_we", 32'(dmem_we), 0);
    checkOutput("t2_addr", dmem_addr, 32'h100);
    idle();
    @(negedge clk);
    checkOutput("t2_rvalid", 32'(c_rvalid), 1);
    checkOutput("t2_rdata", c_rdata, 32'hDEAD_BEEF);

    // D write with C idle: one write strobe, no read response.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 4'hF);
    idle();
    @(negedge clk);
    checkOutput("t4_we", 32'(dmem_we), 1);
    checkOutput("t4_addr", dmem_addr, 32'h200);
    checkOutput("t4_wdata", dmem_wdata, 32'h1234_5678);
    checkOutput("t4_be", 32'(dmem_be), 32'hF);
    idle();
    @(negedge clk);
    checkOutput("t4_we_off", 32'(dmem_we), 0);
    checkOutput("t4_wdata_hold", dmem_wdata, 32'h1234_5678);
    checkOutput("t4_d_rvalid", 32'(d_rvalid), 0);

    // Write with no byte enables is still issued.
    applyStimulus(1, 1, 32'h240, 32'hAAAA_5555, 4'h0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    checkOutput("be0_we", 32'(dmem_we), 1);
    checkOutput("be0_be", 32'(dmem_be), 0);

    // C read then D read on consecutive cycles: responses stay with their owners.
    applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h400, 0, 0);
    idle();
    @(negedge clk);
    checkOutput("t5_c_rv", 32'(c_rvalid), 1);
    checkOutput("t5_d_rv0", 32'(d_rvalid), 0);
    checkOutput("t5_c_data", c_rdata, 32'h0300_FCFF);
    idle();
    @(negedge clk);
    checkOutput("t5_d_rv", 32'(d_rvalid), 1);
    checkOutput("t5_c_rv0", 32'(c_rvalid), 0);
    checkOutput("t5_d_data", d_rdata, 32'h0400_FBFF);

    // Reset right after a read handshake discards the response.
    applyStimulus(1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    c_req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("t6_c_rv", 32'(c_rvalid), 0);
    checkOutput("t6_en", 32'(dmem_en), 0);
    checkOutput("t6_addr", dmem_addr, 0);
    idle();
    @(negedge clk);
    checkOutput("t6_c_rv2", 32'(c_rvalid), 0);

    // Random mixed traffic, checked by the model only.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom),
                    1'($urandom), 1'($urandom), 32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom));
    end
    idle(); idle(); idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
